// File: rtl/dvp_capture.sv
// dvp_capture: DVP camera capture stage feeding the frame assembler.
// Registers the 8-bit YUV422 camera bus, picks the luma byte of every pixel
// pair and forwards it with a 2-bit qualifier (0 blank, 1 pixel, 2 line end,
// 3 frame end). Enforces H_ACTIVE x V_ACTIVE frame geometry and reports each
// frame as well-formed (frame_done) or malformed (frame_error).
// Optional build macro DVP_TEST_PATTERN_EN adds a test_mode input that
// replaces the camera luma with col[7:0] ^ row[7:0].
module dvp_capture #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int Y_FIRST  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
`ifdef DVP_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    input  logic       cam_vsync,
    input  logic       cam_href,
    input  logic [7:0] cam_data,
    output logic [7:0] data,
    output logic [1:0] state,
    output logic [7:0] line_count,
    output logic       frame_done,
    output logic       frame_error
);

    // Geometry limits at counter width; col is 9 bits, row is 8 bits.
    localparam logic [8:0] H_MAX = 9'(H_ACTIVE);
    localparam logic [7:0] V_MAX = 8'(V_ACTIVE);

    // Byte phase that carries luma: 0 for YUYV, 1 for UYVY.
    localparam logic LUMA_PHASE = (Y_FIRST != 0) ? 1'b0 : 1'b1;

    // Output qualifier codes.
    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_PIX   = 2'd1;
    localparam logic [1:0] ST_LEND  = 2'd2;
    localparam logic [1:0] ST_FEND  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_ACTIVE = 2'd2,
        S_END    = 2'd3
    } fsm_t;

    // Saturating increments: a counter parked at all-ones never wraps back
    // into the range of valid column/row numbers.
    function automatic logic [8:0] sat_inc9(input logic [8:0] v);
        return (v == 9'h1FF) ? v : v + 9'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    fsm_t       r_fsm;
    logic       r_vsync;
    logic       r_vsync_d;
    logic       r_href;
    logic       r_href_d;
    logic [7:0] r_data;
    logic       r_phase;
    logic [8:0] r_col;
    logic [7:0] r_row;
    logic       r_err;

    logic       w_vs_rise;
    logic       w_vs_fall;
    logic       w_href_rise;
    logic       w_href_fall;
    logic       w_byte_ok;
    logic       w_cur_phase;
    logic       w_is_luma;
    logic       w_col_ok;
    logic       w_row_ok;
    logic [7:0] w_pix_byte;

    // Input stage: register the camera bus once and keep the previous
    // vsync/href sample for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_href    <= 1'b0;
            r_href_d  <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_vsync   <= cam_vsync;
            r_vsync_d <= r_vsync;
            r_href    <= cam_href;
            r_href_d  <= r_href;
            r_data    <= cam_data;
        end
    end

    // Edge detection, byte phase and luma selection on the registered bus.
    always_comb begin
        w_vs_rise   = r_vsync & ~r_vsync_d;
        w_vs_fall   = ~r_vsync & r_vsync_d;
        w_href_rise = r_href & ~r_href_d;
        w_href_fall = ~r_href & r_href_d;
        // Bytes presented while vsync is high are not part of any line.
        w_byte_ok   = r_href & ~r_vsync;
        // The first byte of every line is phase 0 regardless of history.
        w_cur_phase = w_href_rise ? 1'b0 : r_phase;
        w_is_luma   = w_byte_ok & (w_cur_phase == LUMA_PHASE);
        w_col_ok    = (r_col < H_MAX);
        w_row_ok    = (r_row < V_MAX);
`ifdef DVP_TEST_PATTERN_EN
        w_pix_byte  = test_mode ? (r_col[7:0] ^ r_row[7:0]) : r_data;
`else
        w_pix_byte  = r_data;
`endif
    end

    // Capture FSM with registered outputs, geometry counters and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_phase     <= 1'b0;
            r_col       <= 9'd0;
            r_row       <= 8'd0;
            r_err       <= 1'b0;
            data        <= 8'h00;
            state       <= ST_BLANK;
            line_count  <= 8'd0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= ST_BLANK;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;

            case (r_fsm)
                S_IDLE: begin
                    if (enable) begin
                        r_fsm <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    // Frame starts at the end of the vsync pulse.
                    if (w_vs_fall) begin
                        r_fsm      <= S_ACTIVE;
                        r_phase    <= 1'b0;
                        r_col      <= 9'd0;
                        r_row      <= 8'd0;
                        r_err      <= 1'b0;
                        line_count <= 8'd0;
                    end
                end

                S_ACTIVE: begin
                    if (w_byte_ok) begin
                        r_phase <= ~w_cur_phase;
                        if (w_is_luma) begin
                            if (w_col_ok && w_row_ok) begin
                                data  <= w_pix_byte;
                                state <= ST_PIX;
                                r_col <= sat_inc9(r_col);
                            end else begin
                                // Pixel past the line width or line past the
                                // frame height: dropped and the frame is bad.
                                r_err <= 1'b1;
                            end
                        end
                    end

                    if (w_href_fall) begin
                        if ((r_col != H_MAX) || !w_row_ok) begin
                            r_err <= 1'b1;
                        end
                        if (w_row_ok) begin
                            state      <= ST_LEND;
                            r_row      <= sat_inc8(r_row);
                            line_count <= sat_inc8(r_row);
                        end
                        r_col <= 9'd0;
                    end

                    // A line end in the same cycle is reported first; the
                    // frame end follows from S_END on the next cycle.
                    if (w_vs_rise) begin
                        r_fsm <= S_END;
                    end
                end

                S_END: begin
                    state <= ST_FEND;
                    if ((r_row == V_MAX) && !r_err) begin
                        frame_done <= 1'b1;
                    end else begin
                        frame_error <= 1'b1;
                    end
                    r_fsm <= enable ? S_SYNC : S_IDLE;
                end

                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_capture.sv
// tb_dvp_capture: directed scoreboard bench for dvp_capture on a reduced
// 16x6 geometry. Instance u_dut is YUYV (Y_FIRST=1), u_dut_b is UYVY.
module tb_dvp_capture;

    localparam int H = 16;
    localparam int V = 6;

    typedef struct packed {
        logic       err;
        logic       done;
        logic [1:0] st;
        logic [7:0] d;
        logic [7:0] lc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cam_vsync = 1'b0;
    logic       cam_href = 1'b0;
    logic [7:0] cam_data = 8'h00;

    logic [7:0] data_a;
    logic [1:0] state_a;
    logic [7:0] line_count_a;
    logic       frame_done_a;
    logic       frame_error_a;

    logic [7:0] data_b;
    logic [1:0] state_b;
    logic [7:0] line_count_b;
    logic       frame_done_b;
    logic       frame_error_b;

    ev_t sb[$];
    int  errors = 0;
    int  checks = 0;
    bit  open = 1'b0;
    bit  skip_pulse = 1'b0;
    bit  frm_err = 1'b0;
    int  frm_rows = 0;
    bit  chk_b = 1'b0;
    int  b_pix = 0;

    always #5 clk = ~clk;

    dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_FIRST(1)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
`ifdef DVP_TEST_PATTERN_EN
        .test_mode   (1'b0),
`endif
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .data        (data_a),
        .state       (state_a),
        .line_count  (line_count_a),
        .frame_done  (frame_done_a),
        .frame_error (frame_error_a)
    );

    dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_FIRST(0)) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
`ifdef DVP_TEST_PATTERN_EN
        .test_mode   (1'b0),
`endif
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .data        (data_b),
        .state       (state_b),
        .line_count  (line_count_b),
        .frame_done  (frame_done_b),
        .frame_error (frame_error_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [1:0] st, input logic [7:0] d, input logic [7:0] lc,
                           input logic done, input logic err);
        ev_t e;
        e.err  = err;
        e.done = done;
        e.st   = st;
        e.d    = d;
        e.lc   = lc;
        sb.push_back(e);
    endtask

    // vsync pulse: closes the open frame (if any) and opens the next one.
    task automatic vsync_pulse(input bit junk, input bit already_high);
        bit ok;
        if (!already_high) begin
            tick();
            cam_vsync = 1'b1;
            cam_href  = junk;
            cam_data  = 8'hEE;
        end
        if (open) begin
            ok = (frm_rows == V) && !frm_err;
            push_ev(2'd3, 8'h00, 8'(frm_rows), ok, !ok);
        end
        open = 1'b0;
        tick();
        tick();
        cam_href = 1'b0;
        cam_data = 8'h00;
        tick();
        cam_vsync = 1'b0;
        open      = enable;
        frm_err   = 1'b0;
        frm_rows  = 0;
        repeat (4) tick();
    endtask

    // One camera line of npix pixel pairs. mode 0: YUYV with a ramp luma,
    // mode 1: UYVY with U/V = 0x80 and Y = 0x55.
    task automatic cam_line(input int idx, input int npix, input int mode, input bit tight);
        logic [7:0] b0;
        logic [7:0] b1;
        for (int p = 0; p < npix; p++) begin
            if (mode == 0) begin
                b0 = 8'(p + 16 * idx);
                b1 = 8'h80;
            end else begin
                b0 = 8'h80;
                b1 = 8'h55;
            end
            tick();
            cam_href = 1'b1;
            cam_data = b0;
            if (open && (idx < V) && (p < H)) push_ev(2'd1, b0, 8'(idx), 1'b0, 1'b0);
            tick();
            cam_data = b1;
        end
        tick();
        cam_href = 1'b0;
        cam_data = 8'h00;
        if (tight) cam_vsync = 1'b1;
        if (open) begin
            if ((npix != H) || (idx >= V)) frm_err = 1'b1;
            if (idx < V) begin
                push_ev(2'd2, 8'h00, 8'(idx + 1), 1'b0, 1'b0);
                frm_rows++;
            end
        end
        if (tight) begin
            vsync_pulse(1'b0, 1'b1);
            skip_pulse = 1'b1;
        end else begin
            repeat (3) tick();
        end
    endtask

    task automatic cam_frame(input int nlines, input int bad_line, input int bad_w,
                             input int mode, input int drop_en_at, input bit tight);
        if (skip_pulse) skip_pulse = 1'b0;
        else vsync_pulse(1'b1, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            if (l == drop_en_at) enable = 1'b0;
            cam_line(l, (l == bad_line) ? bad_w : H, mode, tight && (l == nlines - 1));
        end
    endtask

    initial begin
        fork
            begin
                #2000000;
                $display("FAIL watchdog: time limit reached, observed running expected finished");
                $fatal(1, "watchdog");
            end
            begin
                ev_t o;
                ev_t e;
                forever begin
                    @(negedge clk);
                    if (state_a != 2'd0) begin
                        if (sb.size() == 0) begin
                            check("unexpected_state", 32'(state_a), 32'd0);
                        end else begin
                            e      = sb.pop_front();
                            o.err  = frame_error_a;
                            o.done = frame_done_a;
                            o.st   = state_a;
                            o.d    = (state_a == 2'd1) ? data_a : 8'h00;
                            o.lc   = line_count_a;
                            check("scoreboard", 32'(o), 32'(e));
                        end
                    end else if (frame_done_a || frame_error_a) begin
                        check("stray_pulse", {30'd0, frame_done_a, frame_error_a}, 32'd0);
                    end
                    if (chk_b && (state_b == 2'd1)) begin
                        check("uyvy_pixel",
                              {14'd0, frame_done_b, frame_error_b, line_count_b, data_b},
                              {16'd0, 8'(b_pix / H), 8'h55});
                        b_pix++;
                    end
                end
            end
        join_none

        // Power-on reset
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_line_count", 32'(line_count_a), 32'd0);
        check("rst_frame_done", 32'(frame_done_a), 32'd0);
        check("rst_frame_error", 32'(frame_error_a), 32'd0);
        tick();
        rst    = 1'b0;
        enable = 1'b1;
        repeat (2) tick();

        // Well-formed YUYV frame
        cam_frame(V, -1, H, 0, -1, 1'b0);

        // UYVY frame: the Y_FIRST=0 instance must carry 0x55 only
        b_pix = 0;
        chk_b = 1'b1;
        cam_frame(V, -1, H, 1, -1, 1'b0);
        chk_b = 1'b0;
        check("uyvy_count", 32'(b_pix), 32'(H * V));

        // Short line, long line, too many lines
        cam_frame(V, 3, H - 1, 0, -1, 1'b0);
        cam_frame(V, 2, H + 1, 0, -1, 1'b0);
        cam_frame(V + 2, -1, H, 0, -1, 1'b0);

        // Last href fall coincides with vsync rise
        cam_frame(V, -1, H, 0, -1, 1'b1);

        // Reset at line 3, pixel 5
        cam_frame(3, -1, H, 0, -1, 1'b0);
        for (int p = 0; p < 5; p++) begin
            tick();
            cam_href = 1'b1;
            cam_data = 8'(p + 48);
            if (open) push_ev(2'd1, 8'(p + 48), 8'd3, 1'b0, 1'b0);
            tick();
            cam_data = 8'h80;
        end
        tick();
        rst      = 1'b1;
        cam_href = 1'b0;
        cam_data = 8'h00;
        tick();
        rst = 1'b0;
        sb.delete();
        open = 1'b0;
        @(negedge clk);
        check("midrst_data", 32'(data_a), 32'd0);
        check("midrst_state", 32'(state_a), 32'd0);
        check("midrst_line_count", 32'(line_count_a), 32'd0);
        check("midrst_pulses", {30'd0, frame_done_a, frame_error_a}, 32'd0);

        // Clean frame after reset
        cam_frame(V, -1, H, 0, -1, 1'b0);

        // enable dropped at line 2: frame completes, next frame ignored
        cam_frame(V, -1, H, 0, 2, 1'b0);
        cam_frame(V, -1, H, 0, -1, 1'b0);
        vsync_pulse(1'b1, 1'b0);

        repeat (8) tick();
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dvp_capture.md
Name: dvp_capture

Overview:
Camera-side capture stage feeding the frame assembler.
- Samples an 8-bit DVP camera bus (vsync/href/data, YUV422, two bytes per pixel) and extracts the luma byte.
- Emits one 8-bit grayscale pixel per pixel slot on `data`, qualified by a 2-bit `state` code; the downstream assembler consumes only cycles where `state == 1`.
- Enforces 320x240 frame geometry and flags malformed frames.

Parameters:
- H_ACTIVE, 320, pixels per line forwarded downstream
- V_ACTIVE, 240, lines per frame forwarded downstream
- Y_FIRST, 1, 1 = luma is byte 0 of each pixel pair (YUYV); 0 = luma is byte 1 (UYVY)

Ports:
- clk  in  1  camera pixel clock; all camera inputs are synchronous to it
- rst  in  1  synchronous active-high reset
- enable  in  1  arm capture; sampled at frame boundaries
- cam_vsync  in  1  camera vertical sync, active-high pulse between frames
- cam_href  in  1  camera line-valid, high during active bytes
- cam_data  in  8  camera byte bus
- data  out  8  luma pixel to the frame assembler
- state  out  2  0 = blank, 1 = pixel valid, 2 = line end, 3 = frame end
- line_count  out  8  lines forwarded in the current frame (0..V_ACTIVE)
- frame_done  out  1  one-cycle pulse: a complete, well-formed frame was forwarded
- frame_error  out  1  one-cycle pulse: the frame ended with a geometry violation

Behaviour:
- Reset values: data = 0, state = 0, line_count = 0, frame_done = 0, frame_error = 0, FSM = IDLE, all counters and the byte phase = 0.
- Reset mid-frame: all of the above take effect on the next clk; the partial frame is abandoned and no pulse is issued.
- Input stage: cam_vsync, cam_href and cam_data are registered once. Edge detection uses the registered value and its previous value.
- Output latency: 2 clk from the cam_data byte carrying luma to `data`/`state == 1`.
- FSM IDLE: outputs blank. If enable = 1, go to SYNC.
- FSM SYNC: wait for a vsync falling edge, then go to ACTIVE and clear the column, row and error flag.
- FSM ACTIVE, byte phase:
  - Phase toggles on each cycle with href = 1.
  - Phase is forced to 0 on the first href-high cycle of a line.
  - The byte at phase (Y_FIRST ? 0 : 1) is luma.
- FSM ACTIVE, luma bytes: for each luma byte with col < H_ACTIVE and row < V_ACTIVE, output data = byte, state = 1, col++.
  - Luma bytes beyond H_ACTIVE are dropped: state = 0, error flag set.
- FSM ACTIVE, href falling edge:
  - If col != H_ACTIVE (short or long line), set the error flag.
  - If row < V_ACTIVE: state = 2 for one cycle and row++; line_count follows row.
  - Col resets to 0.
  - Lines arriving when row >= V_ACTIVE are dropped entirely (no state 1/2 output) and set the error flag.
- FSM ACTIVE, vsync rising edge: go to END.
- FSM END (one cycle):
  - Output state = 3.
  - Pulse frame_done if row == V_ACTIVE and the error flag is clear; otherwise pulse frame_error.
  - line_count holds its final value until the next frame starts.
  - Go to SYNC if enable = 1, else IDLE.
- enable deasserted mid-frame: the current frame completes normally; enable is re-sampled only in IDLE and END.
- Simultaneous events:
  - href falling and vsync rising in the same cycle: the line end is processed first (state = 2), and END follows on the next cycle.
  - href high while vsync is high: the bytes are ignored.
- Counter widths: col is 9 bits and row is 8 bits. Counters saturate rather than wrap, so overflow cannot alias a valid count.
- Output state values 2 and 3 never coincide with a valid pixel.

Optional Feature:
- Macro: DVP_TEST_PATTERN_EN.
- Defined:
  - Adds input port `test_mode` (1 bit).
  - When test_mode = 1, the luma byte is replaced by col[7:0] ^ row[7:0].
  - All timing, state codes and error checks are unchanged.
  - test_mode is sampled per pixel.
- Undefined: the port is absent and camera luma always passes through.

Test Plan:
- Reset, then enable = 1 and one well-formed 320x240 YUYV frame (Y bytes = col[7:0]) -> 76800 cycles with state = 1 and data matching in order; 240 state = 2 cycles; one state = 3; frame_done = 1, frame_error = 0, line_count = 240.
- Y_FIRST = 0 with UYVY input (U/V = 0x80, Y = 0x55) -> every state = 1 cycle carries data = 0x55, never 0x80.
- Frame with line 17 only 319 pixels wide -> frame_error pulses at END, frame_done stays 0; the other lines are forwarded unchanged.
- Frame of 242 lines -> exactly 240 state = 2 cycles; lines 241-242 produce no output; frame_error = 1.
- rst asserted for 1 cycle at line 100, pixel 50 -> next cycle all outputs are 0; no frame_done/error pulse; the next full frame captures cleanly with frame_done = 1.
- enable dropped at line 10 -> the frame completes with frame_done = 1, then the FSM returns to IDLE and the following camera frame produces state = 0 throughout.
